// File: rtl/leve_pkg.sv
// Shared types and constants for the leve2 instruction fetch unit.
// LEVE_IF_FAULT_EN adds a per-entry AXI fault bit to fetch_entry_t.
package leve_pkg;

    localparam int XLEN               = 32;
    localparam int LEVE_DEPTH_DEFAULT = 4;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
`ifdef LEVE_IF_FAULT_EN
        logic            fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/leve2_fifo.sv
// Synchronous instruction buffer with flush; storage resets to zero so the
// head entry reads as zero under reset.
module leve2_fifo
    import leve_pkg::*;
#(
    parameter  int DEPTH = LEVE_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push_s;
    logic            do_pop_s;

    assign do_push_s = push_i & (cnt_q != CW'(DEPTH));
    assign do_pop_s  = pop_i & (cnt_q != {CW{1'b0}});

    // Pointer, count and storage update; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/leve2_fetch.sv
// Instruction fetch unit: credit-limited AXI read initiator feeding a flushable
// instruction buffer. LEVE_IF_FAULT_EN adds the OFAULT port and fault storage.
module leve2_fetch
    import leve_pkg::*;
#(
    parameter int              DEPTH    = LEVE_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            IPC_WE,
    input  logic [XLEN-1:0] INEXT_PC,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [XLEN-1:0] OPC,
    output logic [31:0]     OINSTR,
`ifdef LEVE_IF_FAULT_EN
    output logic            OFAULT,
`endif
    output logic            RII_ARVALID,
    input  logic            RII_ARREADY,
    output logic [XLEN-1:0] RII_ARADDR,
    input  logic            RII_RVALID,
    output logic            RII_RREADY,
    input  logic [31:0]     RII_RDATA,
    input  logic [1:0]      RII_RRESP
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   occ_s, occ_d;
    logic [CW:0]     credit_s;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            arv_q, arv_d;
    logic            stale_q, stale_d;
    logic            ar_hs_s, pend_s, r_hs_s, drop_s, push_s, pop_s;
    fetch_entry_t    wentry_s, head_s;

    assign ar_hs_s = arv_q & RII_ARREADY;
    assign pend_s  = arv_q & ~RII_ARREADY;
    assign r_hs_s  = RII_RVALID;
    assign drop_s  = r_hs_s & (disc_q != {CW{1'b0}});
    assign push_s  = r_hs_s & (disc_q == {CW{1'b0}}) & ~IPC_WE;
    assign pop_s   = OVALID & OREADY & ~IPC_WE;

    // Build the buffer entry from the R beat and the response PC.
    always_comb begin
        wentry_s       = '0;
        wentry_s.pc    = rpc_q;
        wentry_s.instr = RII_RDATA;
`ifdef LEVE_IF_FAULT_EN
        wentry_s.fault = RII_RRESP[1];
`endif
    end

`ifndef LEVE_IF_FAULT_EN
    logic unused_rresp_s;
    assign unused_rresp_s = ^RII_RRESP;
`endif

    // Next-state for counters, PCs and the AR channel. A pending AR caught by
    // a redirect is marked stale; its beat is discarded once it is accepted.
    always_comb begin
        out_d = out_q + CW'(ar_hs_s) - CW'(r_hs_s);
        if (IPC_WE) begin
            fpc_d   = INEXT_PC;
            rpc_d   = INEXT_PC;
            disc_d  = out_d;
            stale_d = pend_s;
            occ_d   = {CW{1'b0}};
        end else begin
            fpc_d   = (ar_hs_s & ~stale_q) ? (fpc_q + PC_STEP) : fpc_q;
            rpc_d   = push_s ? (rpc_q + PC_STEP) : rpc_q;
            disc_d  = disc_q - CW'(drop_s) + CW'(ar_hs_s & stale_q);
            stale_d = stale_q & pend_s;
            occ_d   = occ_s + CW'(push_s) - CW'(pop_s);
        end
        credit_s = {1'b0, occ_d} + {1'b0, out_d};
        arv_d    = pend_s | (credit_s < (CW+1)'(DEPTH));
        araddr_d = pend_s ? araddr_q : fpc_d;
    end

    // Fetch-side state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_q    <= {CW{1'b0}};
            disc_q   <= {CW{1'b0}};
            fpc_q    <= RESET_PC;
            rpc_q    <= RESET_PC;
            araddr_q <= RESET_PC;
            arv_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            disc_q   <= disc_d;
            fpc_q    <= fpc_d;
            rpc_q    <= rpc_d;
            araddr_q <= araddr_d;
            arv_q    <= arv_d;
            stale_q  <= stale_d;
        end
    end

    leve2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RSTn),
        .push_i  (push_s),
        .wdata_i (wentry_s),
        .pop_i   (pop_s),
        .flush_i (IPC_WE),
        .head_o  (head_s),
        .count_o (occ_s)
    );

    assign OVALID      = (occ_s != {CW{1'b0}});
    assign OPC         = head_s.pc;
    assign OINSTR      = head_s.instr;
`ifdef LEVE_IF_FAULT_EN
    assign OFAULT      = head_s.fault;
`endif
    assign RII_ARVALID = arv_q;
    assign RII_ARADDR  = araddr_q;
    assign RII_RREADY  = 1'b1;

endmodule

// File: tb/tb_leve2_fetch.sv
// Randomized bench for leve2_fetch against an in-order AXI memory model and an
// expected-stream reference (redirect target, then +4 per delivered word).
module tb_leve2_fetch;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        IPC_WE = 1'b0;
    logic [31:0] INEXT_PC = 32'h0;
    logic        OVALID;
    logic        OREADY = 1'b0;
    logic [31:0] OPC;
    logic [31:0] OINSTR;
`ifdef LEVE_IF_FAULT_EN
    logic        OFAULT;
`endif
    logic        RII_ARVALID;
    logic        RII_ARREADY = 1'b0;
    logic [31:0] RII_ARADDR;
    logic        RII_RVALID = 1'b0;
    logic        RII_RREADY;
    logic [31:0] RII_RDATA = 32'h0;
    logic [1:0]  RII_RRESP = 2'b00;

    leve2_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .IPC_WE      (IPC_WE),
        .INEXT_PC    (INEXT_PC),
        .OVALID      (OVALID),
        .OREADY      (OREADY),
        .OPC         (OPC),
        .OINSTR      (OINSTR),
`ifdef LEVE_IF_FAULT_EN
        .OFAULT      (OFAULT),
`endif
        .RII_ARVALID (RII_ARVALID),
        .RII_ARREADY (RII_ARREADY),
        .RII_ARADDR  (RII_ARADDR),
        .RII_RVALID  (RII_RVALID),
        .RII_RREADY  (RII_RREADY),
        .RII_RDATA   (RII_RDATA),
        .RII_RRESP   (RII_RRESP)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          now = 0;
    int          n_ar = 0;
    logic [31:0] q_addr[$];
    int          q_rdy[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_ar = 32'h0;
    logic        stale = 1'b0;
    logic [31:0] held_a = 32'h0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_ara = 32'h0;
    logic        prev_ohold = 1'b0;
    logic [31:0] prev_opc = 32'h0;
    logic [31:0] prev_oin = 32'h0;

    function automatic logic [31:0] mix(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic fault_of(input logic [31:0] a);
        return (a[4:2] == 3'd2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the negedge, drive inputs, advance the model.
    task automatic step(input int p_ar, input int p_or, input int max_lat, input int p_ipc);
        logic        arv, ov, ard, ord, rv, ipc;
        logic [31:0] ara, opc, oin, tgt, rd;
        logic [1:0]  rr;
        arv = RII_ARVALID;
        ara = RII_ARADDR;
        ov  = OVALID;
        opc = OPC;
        oin = OINSTR;
        if (prev_pend) begin
            chk("ar_hold_valid", {31'h0, arv}, 32'h1);
            chk("ar_hold_addr", ara, prev_ara);
        end
        if (prev_ohold) begin
            chk("o_hold_valid", {31'h0, ov}, 32'h1);
            chk("o_hold_pc", opc, prev_opc);
            chk("o_hold_instr", oin, prev_oin);
        end
        ard = ($urandom_range(0, 99) < p_ar);
        ord = ($urandom_range(0, 99) < p_or);
        ipc = ($urandom_range(0, 99) < p_ipc);
        tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
        rv  = (q_addr.size() > 0) && (q_rdy[0] <= now);
        if (rv) begin
            rd = mix(q_addr[0]);
            rr = {fault_of(q_addr[0]), 1'($urandom)};
        end else begin
            rd = $urandom;
            rr = 2'($urandom);
        end
        RII_ARREADY = ard;
        OREADY      = ord;
        RII_RVALID  = rv;
        RII_RDATA   = rd;
        RII_RRESP   = rr;
        IPC_WE      = ipc;
        INEXT_PC    = tgt;
        if (ov && ord) begin
            chk("opc", opc, exp_pc);
            chk("oinstr", oin, mix(exp_pc));
`ifdef LEVE_IF_FAULT_EN
            chk("ofault", {31'h0, OFAULT}, {31'h0, fault_of(exp_pc)});
`endif
            exp_pc = exp_pc + 32'd4;
        end
        if (arv && ard) begin
            chk("araddr", ara, stale ? held_a : exp_ar);
            if (!stale) exp_ar = exp_ar + 32'd4;
            stale = 1'b0;
            q_addr.push_back(ara);
            q_rdy.push_back(now + 1 + $urandom_range(0, max_lat));
            n_ar++;
            chk("reads_in_flight_le_depth", {31'h0, q_addr.size() <= DEPTH}, 32'h1);
        end
        if (rv) begin
            void'(q_addr.pop_front());
            void'(q_rdy.pop_front());
        end
        if (ipc) begin
            exp_pc = tgt;
            exp_ar = tgt;
            if (arv && !ard) begin
                stale  = 1'b1;
                held_a = ara;
            end
        end
        prev_pend  = arv && !ard;
        prev_ara   = ara;
        prev_ohold = ov && !ord && !ipc;
        prev_opc   = opc;
        prev_oin   = oin;
        @(negedge CLK);
        now++;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_arvalid", {31'h0, RII_ARVALID}, 32'h0);
        chk("rst_ovalid", {31'h0, OVALID}, 32'h0);
        chk("rst_opc", OPC, 32'h0);
        chk("rst_oinstr", OINSTR, 32'h0);
`ifdef LEVE_IF_FAULT_EN
        chk("rst_ofault", {31'h0, OFAULT}, 32'h0);
`endif
        RSTn = 1'b1;
        @(negedge CLK);
        chk("first_arvalid", {31'h0, RII_ARVALID}, 32'h1);
        chk("first_araddr", RII_ARADDR, 32'h0);
        chk("rready", {31'h0, RII_RREADY}, 32'h1);

        // Consumer stalled: exactly DEPTH reads, then the AR channel idles.
        repeat (12) step(100, 0, 0, 0);
        chk("stall_ar_count", n_ar, DEPTH);
        chk("stall_arvalid", {31'h0, RII_ARVALID}, 32'h0);
        chk("stall_ovalid", {31'h0, OVALID}, 32'h1);
        step(100, 100, 0, 0);
        chk("ar_resume", {31'h0, RII_ARVALID}, 32'h1);
        repeat (20) step(100, 100, 0, 0);

        repeat (3000) step(50, 70, 3, 5);
        repeat (1500) step(30, 50, 4, 25);
        repeat (60) step(100, 100, 0, 0);
        chk("drain_ovalid", {31'h0, OVALID}, 32'h1);

        #2 RSTn = 1'b0;
        #1;
        chk("async_rst_arvalid", {31'h0, RII_ARVALID}, 32'h0);
        chk("async_rst_ovalid", {31'h0, OVALID}, 32'h0);
        chk("async_rst_opc", OPC, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/leve2_fetch.md
LEVE2_FETCH -- requirements
Module: leve2_fetch

Interface
REQ-001 Parameter DEPTH, default 4, means instruction-buffer entries and maximum outstanding reads; legal values are 2, 4, 8 or 16.
REQ-002 Parameter RESET_PC, default 0, means the first fetch address after reset; it is XLEN bits wide.
REQ-003 CLK  in  1  means the single clock; all state changes on the rising edge.
REQ-004 RSTn  in  1  means asynchronous active-low reset.
REQ-005 IPC_WE  in  1  means a redirect request from EX; it is valid in one cycle.
REQ-006 INEXT_PC  in  XLEN  means the redirect target, sampled when IPC_WE=1.
REQ-007 OVALID  out  1  means an instruction is available to ID.
REQ-008 OREADY  in  1  means ID accepts the instruction; a transfer occurs when OVALID&OREADY.
REQ-009 OPC  out  XLEN  means the address of OINSTR.
REQ-010 OINSTR  out  32  means the fetched instruction word.
REQ-011 OFAULT  out  1  means the entry returned an AXI error; the port exists only under LEVE_IF_FAULT_EN.
REQ-012 RII  AXIR.init  means the instruction read initiator (AR and R channels).

Function
REQ-013 ARVALID asserts when (buffer occupancy + outstanding reads) < DEPTH.
REQ-014 ARADDR = fetch PC; fetch PC increments by 4 (mod 2^XLEN) on each AR handshake.
REQ-015 Once asserted, ARVALID/ARADDR hold stable until ARREADY, including across a redirect.
REQ-016 RREADY is constant 1; credit accounting (REQ-013) guarantees buffer space.
REQ-017 Accepted R beat with discard count 0 pushes {resp PC, RDATA[31:0]} into the buffer; resp PC then increments by 4.
REQ-018 Accepted R beat with discard count >0 is dropped; discard count decrements.
REQ-019 Latency: RVALID handshake at edge N gives OVALID=1 after edge N; there is no combinational R-to-O path.
REQ-020 OVALID = buffer not empty; OPC/OINSTR show the head entry and hold stable while OVALID&!OREADY.
REQ-021 A transfer pops the head entry; push and pop in the same cycle leave occupancy unchanged.
REQ-022 IPC_WE=1 at edge N clears the buffer, loads fetch PC and resp PC with INEXT_PC, and sets discard count to reads outstanding after edge N.
REQ-023 AR held pending at a redirect adds 1 to discard count when it is accepted; the next new AR uses INEXT_PC.
REQ-024 IPC_WE overrides a simultaneous push and pop: buffer empty after the edge, and the R beat of that cycle counts as discarded/dropped.
REQ-025 Back-to-back IPC_WE cycles are legal; the last target wins.
REQ-026 Outstanding and discard counters are $clog2(DEPTH)+1 bits wide and never exceed DEPTH.

Reset
REQ-027 RSTn=0 asynchronously clears buffer, outstanding and discard counts, ARVALID, OVALID and OFAULT.
REQ-028 Under reset, fetch PC and resp PC are RESET_PC and OPC/OINSTR are 0.
REQ-029 First ARVALID occurs at the first edge after RSTn deasserts.
REQ-030 Reset mid-transaction abandons the AR/R state; the interconnect is reset together with this block.

Configuration
REQ-031 With LEVE_IF_FAULT_EN defined: RRESP[1] is stored per entry and presented on OFAULT with its entry.
REQ-032 With LEVE_IF_FAULT_EN defined: a faulting entry does not stop fetching.
REQ-033 Without LEVE_IF_FAULT_EN: the OFAULT port and the storage bit are absent and RRESP is ignored.

Structure
REQ-034 leve_pkg holds typedef fetch_entry_t {pc, instr, fault} and the default DEPTH constant.
REQ-035 Buffer is sub-module leve2_fifo: synchronous, parametric depth, with flush input.

Verification
REQ-036 Reset release, ARREADY=1, 1-cycle R latency, OREADY=1 -> ARADDR 0,4,8,...; OPC 0,4,8 with matching OINSTR.
REQ-037 DEPTH=4, OREADY=0 -> exactly 4 ARs issued, then ARVALID=0; OREADY=1 -> AR resumes one cycle after the first pop.
REQ-038 3 reads outstanding, IPC_WE with INEXT_PC=0x100 -> 3 R beats dropped; next OPC=0x100.
REQ-039 ARVALID held with ARREADY=0 at address 0x20, IPC_WE to 0x80 -> ARADDR stays 0x20 until accepted; its beat is dropped; next ARADDR=0x80.
REQ-040 IPC_WE in the same cycle as push and pop -> buffer empty after the edge; OVALID=0 the next cycle.
REQ-041 LEVE_IF_FAULT_EN defined, RRESP=2'b10 at 0x8 -> OFAULT=1 only with OPC=0x8; entries before and after have OFAULT=0.
